// File: rtl/lsu_64bit.sv
// Load/store unit: one aligned 64-bit bus transaction per op, lane-shifted data and byte enables.
// Optional LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of forcing natural alignment.
module lsu_64bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef struct packed {
    logic [2:0] f3;
    logic [2:0] off;
  } req_t;

  state_t      state, nxt;
  req_t        req;
  logic [2:0]  szm, off_al;
  logic        illegal, fault_in;
  logic [7:0]  be_in;
  logic [63:0] wd_in, sh, ld_ext;
  logic        accept;

  assign accept = (state == IDLE) && lsu_valid;

  // szm is size-1: low offset bits that must be zero for a natural alignment
  always_comb begin
    szm   = 3'b000;
    be_in = 8'h01;
    unique case (funct3[1:0])
      2'd0: begin szm = 3'b000; be_in = 8'h01; end
      2'd1: begin szm = 3'b001; be_in = 8'h03; end
      2'd2: begin szm = 3'b011; be_in = 8'h0F; end
      default: begin szm = 3'b111; be_in = 8'hFF; end
    endcase
    off_al  = addr[2:0] & ~szm;
    be_in   = be_in << off_al;
    wd_in   = wdata << {off_al, 3'b000};
    illegal = is_store ? funct3[2] : (funct3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    fault_in = illegal | (|(addr[2:0] & szm));
`else
    fault_in = illegal;
`endif
  end

  always_comb begin
    sh     = mem_rdata >> {req.off, 3'b000};
    ld_ext = '0;
    case (req.f3)
      3'b000: ld_ext = {{56{sh[7]}}, sh[7:0]};
      3'b001: ld_ext = {{48{sh[15]}}, sh[15:0]};
      3'b010: ld_ext = {{32{sh[31]}}, sh[31:0]};
      3'b011: ld_ext = sh;
      3'b100: ld_ext = {56'd0, sh[7:0]};
      3'b101: ld_ext = {48'd0, sh[15:0]};
      3'b110: ld_ext = {32'd0, sh[31:0]};
      default: ld_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (lsu_valid) nxt = fault_in ? DONE : REQ;
      REQ:  if (mem_req_ready) nxt = WAIT;
      WAIT: if (mem_rsp_valid) nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    lsu_ready     = (state == IDLE);
    mem_req_valid = (state == REQ);
    rsp_valid     = (state == DONE);
  end

  // bus fields only load on accept, so they stay stable for the whole transaction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      req       <= '{f3: funct3, off: off_al};
      mem_we    <= is_store;
      mem_addr  <= {addr[63:3], 3'b000};
      mem_be    <= be_in;
      mem_wdata <= wd_in;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
    end else if (accept && fault_in) begin
      rsp_fault <= 1'b1;
      rsp_rdata <= '0;
    end else if ((state == WAIT) && mem_rsp_valid) begin
      rsp_fault <= 1'b0;
      rsp_rdata <= mem_we ? 64'd0 : ld_ext;
    end
endmodule
